cfu_l2_buf: RTL and testbench
=============================

Name: cfu_l2_buf

Overview:
- Elastic CFU-L2 request/response buffer between a CPU-side CFU-L2 initiator and a CFU-L2 responder (e.g. the mulacc L2 unit).
- The block decouples request backpressure from response timing.
- It caps in-flight requests so the responder's responses are always accepted.
- It preserves request order; CFU-L2 responders return responses in order.

Parameters:
- CFU_CFU_ID_W, 1, width of req_cfu
- CFU_STATE_ID_W, 1, width of req_state
- CFU_FUNC_ID_W, 10, width of req_func
- CFU_DATA_W, 32, width of data operands and response data
- REQ_DEPTH, 2, request FIFO entries; power of 2, >=2
- RESP_DEPTH, 4, response FIFO entries and max outstanding credit; power of 2, >=2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  clock enable; all state holds when low
- req_valid  in  1  initiator request valid
- req_ready  out  1  buffer can accept a request
- req_cfu/req_state/req_func  in  CFU_CFU_ID_W/CFU_STATE_ID_W/CFU_FUNC_ID_W  request IDs
- req_data0/req_data1  in  CFU_DATA_W  operands
- resp_valid  out  1  response to initiator valid
- resp_ready  in  1  initiator accepts response
- resp_status  out  3  CFU status
- resp_data  out  CFU_DATA_W  result
- t_req_valid  out  1  request to responder valid
- t_req_ready  in  1  responder accepts request
- t_req_cfu/t_req_state/t_req_func/t_req_data0/t_req_data1  out  as above  forwarded request fields
- t_resp_valid  in  1  responder response valid
- t_resp_ready  out  1  equals clk_en
- t_resp_status  in  3  responder status
- t_resp_data  in  CFU_DATA_W  responder data

Behaviour:
- Reset (async, rst=1): both FIFOs empty; outstanding counter out_cnt=0; req_ready=1, resp_valid=0, t_req_valid=0; data outputs 0.
- Handshakes:
  - Transfer occurs on a rising clk edge with valid&ready&clk_en.
  - Once a valid is asserted, it and its payload stay stable until the transfer.
- Request FIFO:
  - req_ready = !req_full.
  - Accept at edge N -> t_req_valid=1 from cycle N+1 (registered, no bypass).
  - t_req_valid = !req_empty & credit_ok, where credit_ok = (out_cnt + resp_count) < RESP_DEPTH.
  - Head fields are driven directly from the FIFO storage.
- Outstanding counter out_cnt (width clog2(RESP_DEPTH)+1):
  - +1 on a t_req transfer; -1 on a t_resp transfer.
  - Both on the same edge: no change.
  - Never exceeds RESP_DEPTH.
- Response FIFO:
  - Captures {t_resp_status, t_resp_data} on t_resp_valid&clk_en.
  - The credit rule guarantees a free entry.
  - resp_valid = !resp_empty; entry visible the cycle after capture.
  - Pops on resp_valid&resp_ready.
- Simultaneous push/pop on a full request FIFO:
  - Not allowed; req_ready=0 when full, with no same-cycle pass-through.
  - Push and pop on a non-full FIFO both occur; count unchanged.
- Pointers wrap modulo depth; full/empty use an extra MSB on the pointers.
- Latency: initiator request to responder >=1 cycle; responder response to initiator >=1 cycle.
  - Minimum round trip with a 0-latency responder: 2 cycles.
- clk_en=0:
  - No pointer or counter updates; outputs hold.
  - t_resp_ready=0; req_ready still reflects full.
  - No transfer occurs.
- rst mid-operation: all buffered requests, responses and credits are discarded immediately; the responder must be reset together with this block.
- Protocol error: t_resp_valid while out_cnt==0 is ignored (no push). It triggers an assertion under simulation.

Optional Feature:
- CFU_L2_BUF_STATS_EN defined adds three output ports:
  - stat_req  out  32: saturating count of t_req transfers.
  - stat_stall  out  32: saturating count of cycles with !req_empty & !credit_ok & clk_en.
  - stat_peak  out  clog2(RESP_DEPTH)+1: max out_cnt seen.
- All three are reset to 0 by rst.
- Without the macro, these ports and their logic do not exist; core behaviour is identical in both builds.

Test Plan:
- Single op: after reset, with t_req_ready=1 and a responder returning data0*data1 the next cycle, req {func=0, data0=3, data1=5} -> t_req_valid 1 cycle later; resp_valid with resp_data=15, status=0 at cycle 3 after accept.
- Backpressure: t_req_ready=0; issue 3 requests with REQ_DEPTH=2 -> first two accepted, req_ready=0 on 3rd; release -> in-order delivery of data0=1,2,3.
- Credit limit: resp_ready=0, RESP_DEPTH=4, 6 requests with responder returning immediately -> exactly 4 t_req transfers then t_req_valid=0; stat_stall increments. Pop one response -> 5th issues next cycle.
- Wrap-around: 20 back-to-back ops, data0=i, data1=1, with random resp_ready -> responses 0..19 in order, no drops or duplicates, out_cnt returns to 0.
- clk_en: drop clk_en for 5 cycles mid-stream -> no transfers, outputs stable, t_resp_ready=0; resume -> sequence intact.
- Async reset with 2 requests queued and 2 outstanding: assert rst between edges -> req_ready=1, resp_valid=0, t_req_valid=0 immediately; stat_* = 0.

Source files
------------

// File: rtl/cfu_l2_buf.sv
// cfu_l2_buf: elastic CFU-L2 request/response buffer with credit-limited issue toward the responder.
// Define CFU_L2_BUF_STATS_EN to add the stat_req / stat_stall / stat_peak counters.
module cfu_l2_buf #(
  parameter int CFU_CFU_ID_W   = 1,
  parameter int CFU_STATE_ID_W = 1,
  parameter int CFU_FUNC_ID_W  = 10,
  parameter int CFU_DATA_W     = 32,
  parameter int REQ_DEPTH      = 2,
  parameter int RESP_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [CFU_CFU_ID_W-1:0]   req_cfu,
  input  logic [CFU_STATE_ID_W-1:0] req_state,
  input  logic [CFU_FUNC_ID_W-1:0]  req_func,
  input  logic [CFU_DATA_W-1:0]     req_data0,
  input  logic [CFU_DATA_W-1:0]     req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [2:0]                resp_status,
  output logic [CFU_DATA_W-1:0]     resp_data,
  output logic                      t_req_valid,
  input  logic                      t_req_ready,
  output logic [CFU_CFU_ID_W-1:0]   t_req_cfu,
  output logic [CFU_STATE_ID_W-1:0] t_req_state,
  output logic [CFU_FUNC_ID_W-1:0]  t_req_func,
  output logic [CFU_DATA_W-1:0]     t_req_data0,
  output logic [CFU_DATA_W-1:0]     t_req_data1,
  input  logic                      t_resp_valid,
  output logic                      t_resp_ready,
  input  logic [2:0]                t_resp_status,
  input  logic [CFU_DATA_W-1:0]     t_resp_data
`ifdef CFU_L2_BUF_STATS_EN
  ,
  output logic [31:0]                   stat_req,
  output logic [31:0]                   stat_stall,
  output logic [$clog2(RESP_DEPTH):0]   stat_peak
`endif
);

  localparam int RA = $clog2(REQ_DEPTH);
  localparam int SA = $clog2(RESP_DEPTH);
  localparam logic [RA:0]   REQ_ONE    = 1;
  localparam logic [SA:0]   RESP_ONE   = 1;
  localparam logic [SA+1:0] CREDIT_MAX = (SA+2)'(RESP_DEPTH);

  typedef struct packed {
    logic [CFU_CFU_ID_W-1:0]   cfu;
    logic [CFU_STATE_ID_W-1:0] state;
    logic [CFU_FUNC_ID_W-1:0]  func;
    logic [CFU_DATA_W-1:0]     data0;
    logic [CFU_DATA_W-1:0]     data1;
  } req_t;

  typedef struct packed {
    logic [2:0]            status;
    logic [CFU_DATA_W-1:0] data;
  } resp_t;

  req_t        req_mem_q  [REQ_DEPTH];
  resp_t       resp_mem_q [RESP_DEPTH];
  logic [RA:0] req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [SA:0] resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic [SA:0] out_cnt_q, out_cnt_d;
  logic [SA:0] resp_count;
  logic [SA+1:0] credit_sum;
  logic req_full, req_empty, resp_empty, credit_ok;
  logic req_push, req_pop, resp_push, resp_pop;
  req_t  req_in, req_head;
  resp_t resp_in, resp_head;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  assign req_empty  = (req_wr_q == req_rd_q);
  assign req_full   = (req_wr_q == {~req_rd_q[RA], req_rd_q[RA-1:0]});
  assign resp_empty = (resp_wr_q == resp_rd_q);
  assign resp_count = resp_wr_q - resp_rd_q;

  // Issue only while every in-flight request is guaranteed a response slot.
  assign credit_sum = {1'b0, out_cnt_q} + {1'b0, resp_count};
  assign credit_ok  = (credit_sum < CREDIT_MAX);

  assign req_ready    = !req_full;
  assign t_req_valid  = !req_empty && credit_ok;
  assign resp_valid   = !resp_empty;
  assign t_resp_ready = clk_en;

  assign req_push  = req_valid && req_ready && clk_en;
  assign req_pop   = t_req_valid && t_req_ready && clk_en;
  assign resp_push = t_resp_valid && clk_en && (out_cnt_q != '0);
  assign resp_pop  = resp_valid && resp_ready && clk_en;

  assign req_in  = {req_cfu, req_state, req_func, req_data0, req_data1};
  assign resp_in = {t_resp_status, t_resp_data};

  assign req_head    = req_mem_q[req_rd_q[RA-1:0]];
  assign t_req_cfu   = req_head.cfu;
  assign t_req_state = req_head.state;
  assign t_req_func  = req_head.func;
  assign t_req_data0 = req_head.data0;
  assign t_req_data1 = req_head.data1;

  assign resp_head   = resp_mem_q[resp_rd_q[SA-1:0]];
  assign resp_status = resp_head.status;
  assign resp_data   = resp_head.data;

  always_comb begin
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    resp_wr_d = resp_wr_q;
    resp_rd_d = resp_rd_q;
    out_cnt_d = out_cnt_q;
    if (req_push)  req_wr_d  = req_wr_q + REQ_ONE;
    if (req_pop)   req_rd_d  = req_rd_q + REQ_ONE;
    if (resp_push) resp_wr_d = resp_wr_q + RESP_ONE;
    if (resp_pop)  resp_rd_d = resp_rd_q + RESP_ONE;
    case ({req_pop, resp_push})
      2'b10:   out_cnt_d = out_cnt_q + RESP_ONE;
      2'b01:   out_cnt_d = out_cnt_q - RESP_ONE;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr_q  <= '0;
      req_rd_q  <= '0;
      resp_wr_q <= '0;
      resp_rd_q <= '0;
      out_cnt_q <= '0;
    end else begin
      req_wr_q  <= req_wr_d;
      req_rd_q  <= req_rd_d;
      resp_wr_q <= resp_wr_d;
      resp_rd_q <= resp_rd_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Storage is cleared on reset so the head-driven data outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REQ_DEPTH; i++) req_mem_q[i] <= '0;
    end else if (req_push) begin
      req_mem_q[req_wr_q[RA-1:0]] <= req_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RESP_DEPTH; i++) resp_mem_q[i] <= '0;
    end else if (resp_push) begin
      resp_mem_q[resp_wr_q[SA-1:0]] <= resp_in;
    end
  end

`ifdef CFU_L2_BUF_STATS_EN
  logic [31:0] stat_req_q, stat_req_d, stat_stall_q, stat_stall_d;
  logic [SA:0] stat_peak_q, stat_peak_d;

  always_comb begin
    stat_req_d   = stat_req_q;
    stat_stall_d = stat_stall_q;
    stat_peak_d  = stat_peak_q;
    if (req_pop && (stat_req_q != '1)) stat_req_d = stat_req_q + 32'd1;
    if (clk_en && !req_empty && !credit_ok && (stat_stall_q != '1))
      stat_stall_d = stat_stall_q + 32'd1;
    if (out_cnt_d > stat_peak_q) stat_peak_d = out_cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_q   <= '0;
      stat_stall_q <= '0;
      stat_peak_q  <= '0;
    end else begin
      stat_req_q   <= stat_req_d;
      stat_stall_q <= stat_stall_d;
      stat_peak_q  <= stat_peak_d;
    end
  end

  assign stat_req   = stat_req_q;
  assign stat_stall = stat_stall_q;
  assign stat_peak  = stat_peak_q;
`endif

  // A response with nothing outstanding is a responder protocol error; it is dropped.
  a_resp_without_credit: assert property (@(posedge clk) disable iff (rst)
    (clk_en && t_resp_valid) |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_cfu_l2_buf.sv
// Directed + randomized bench for cfu_l2_buf: a 1-cycle multiply responder and an in-order scoreboard.
module tb_cfu_l2_buf;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [0:0]    req_cfu = '0;
  logic [0:0]    req_state = '0;
  logic [9:0]    req_func = '0;
  logic [DW-1:0] req_data0 = '0;
  logic [DW-1:0] req_data1 = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [2:0]    resp_status;
  logic [DW-1:0] resp_data;
  logic          t_req_valid;
  logic          t_req_ready = 1'b1;
  logic [0:0]    t_req_cfu;
  logic [0:0]    t_req_state;
  logic [9:0]    t_req_func;
  logic [DW-1:0] t_req_data0;
  logic [DW-1:0] t_req_data1;
  logic          t_resp_valid;
  logic          t_resp_ready;
  logic [2:0]    t_resp_status;
  logic [DW-1:0] t_resp_data;
`ifdef CFU_L2_BUF_STATS_EN
  logic [31:0]   stat_req;
  logic [31:0]   stat_stall;
  logic [2:0]    stat_peak;
`endif

  int n_checks = 0;
  int n_pass = 0;
  int n_treq = 0;
  int n_resp = 0;
  bit hold = 1'b0;
  bit rand_rr = 1'b0;
  logic [34:0] exp_q[$];
  logic [34:0] rq[$];
  logic [31:0] treq_log[$];

  cfu_l2_buf dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cfu(req_cfu), .req_state(req_state), .req_func(req_func),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_data(resp_data),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
    .t_req_cfu(t_req_cfu), .t_req_state(t_req_state), .t_req_func(t_req_func),
    .t_req_data0(t_req_data0), .t_req_data1(t_req_data1),
    .t_resp_valid(t_resp_valid), .t_resp_ready(t_resp_ready),
    .t_resp_status(t_resp_status), .t_resp_data(t_resp_data)
`ifdef CFU_L2_BUF_STATS_EN
    , .stat_req(stat_req), .stat_stall(stat_stall), .stat_peak(stat_peak)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Mid-cycle monitor: everything sampled here is what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst && clk_en) begin
      if (t_resp_valid && t_resp_ready && rq.size() != 0) void'(rq.pop_front());
      if (t_req_valid && t_req_ready) begin
        n_treq++;
        treq_log.push_back(t_req_data0);
        rq.push_back({t_req_func[2:0], t_req_data0 * t_req_data1});
      end
      if (req_valid && req_ready) exp_q.push_back({req_func[2:0], req_data0 * req_data1});
      if (resp_valid && resp_ready) begin : b_pop
        logic [34:0] e;
        n_resp++;
        if (exp_q.size() == 0) begin
          check("resp_extra", 64'(resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_data", 64'(resp_data), 64'(e[31:0]));
          check("resp_status", 64'(resp_status), 64'(e[34:32]));
        end
      end
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    rq.delete();
  end

  // Responder: returns {func[2:0], data0*data1} one cycle after each accepted request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t_resp_valid  <= 1'b0;
      t_resp_status <= '0;
      t_resp_data   <= '0;
    end else begin
      t_resp_valid <= (rq.size() != 0) && !hold;
      if (rq.size() != 0) begin
        t_resp_status <= rq[0][34:32];
        t_resp_data   <= rq[0][31:0];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rr) resp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic present(input logic [31:0] d0, input logic [31:0] d1, input logic [9:0] f);
    req_valid = 1'b1;
    req_data0 = d0;
    req_data1 = d1;
    req_func  = f;
  endtask

  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      ok = req_ready && clk_en;
      tick();
    end
    req_valid = 1'b0;
    check(tag, 64'(ok), 64'd1);
  endtask

  task automatic send(input logic [31:0] d0, input logic [31:0] d1, input logic [9:0] f);
    present(d0, d1, f);
    wait_accept("accept");
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || resp_valid); k++) tick();
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] snap();
    return 64'({req_ready, resp_valid, resp_status, t_req_valid, resp_data[15:0], t_req_data0[15:0]});
  endfunction

  initial begin
    int base;
    int base_r;
    logic [63:0] s0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_t_req_valid", 64'(t_req_valid), 64'd0);
    check("rst_resp_data", 64'({resp_status, resp_data}), 64'd0);
    check("rst_t_req_data", 64'({t_req_data0, t_req_data1}), 64'd0);
    check("rst_t_resp_ready", 64'(t_resp_ready), 64'd1);
`ifdef CFU_L2_BUF_STATS_EN
    check("rst_stats", 64'({stat_req, stat_stall}) | 64'(stat_peak), 64'd0);
`endif
    rst = 1'b0;
    tick();

    // Single op: 3*5 -> 15, response visible two edges after the accept edge
    req_cfu = 1'b1;
    req_state = 1'b1;
    present(3, 5, 10'd0);
    wait_accept("single_accept");
    check("single_t_req_valid", 64'(t_req_valid), 64'd1);
    check("single_t_req_data", 64'({t_req_data0, t_req_data1}), {32'd3, 32'd5});
    check("single_t_req_ids", 64'({t_req_cfu, t_req_state, t_req_func}), 64'({1'b1, 1'b1, 10'd0}));
    tick();
    check("single_resp_early", 64'(resp_valid), 64'd0);
    tick();
    check("single_resp_valid", 64'(resp_valid), 64'd1);
    check("single_resp", 64'({resp_status, resp_data}), 64'({3'd0, 32'd15}));
    req_cfu = 1'b0;
    req_state = 1'b0;
    drain();

    // Backpressure: two requests fill the FIFO, third waits, order preserved
    treq_log.delete();
    t_req_ready = 1'b0;
    send(1, 7, 10'd1);
    send(2, 7, 10'd2);
    check("bp_full", 64'(req_ready), 64'd0);
    present(3, 7, 10'd3);
    repeat (3) tick();
    check("bp_still_full", 64'(req_ready), 64'd0);
    check("bp_head", 64'(t_req_data0), 64'd1);
    t_req_ready = 1'b1;
    wait_accept("bp_third_accept");
    drain();
    check("bp_count", 64'(treq_log.size()), 64'd3);
    check("bp_order", 64'({treq_log[0][7:0], treq_log[1][7:0], treq_log[2][7:0]}), 64'h010203);

    // Credit limit: responses not drained, only RESP_DEPTH requests issue
    resp_ready = 1'b0;
    base = n_treq;
    for (int i = 0; i < 6; i++) send(32'(10 + i), 2, 10'(i));
    repeat (6) tick();
    check("credit_issued", 64'(n_treq - base), 64'd4);
    check("credit_t_req_valid", 64'(t_req_valid), 64'd0);
    check("credit_resp_valid", 64'(resp_valid), 64'd1);
    check("credit_req_full", 64'(req_ready), 64'd0);
`ifdef CFU_L2_BUF_STATS_EN
    check("credit_stall", 64'(stat_stall != 0), 64'd1);
`endif
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("credit_reopen", 64'(t_req_valid), 64'd1);
    check("credit_fifth_head", 64'(t_req_data0), 64'd14);
    tick();
    check("credit_fifth_issued", 64'(n_treq - base), 64'd5);
    resp_ready = 1'b1;
    drain();

    // Wrap-around: 20 back-to-back ops with random initiator backpressure
    base_r = n_resp;
    rand_rr = 1'b1;
    for (int i = 0; i < 20; i++) send(32'(i), 1, 10'(i));
    drain();
    rand_rr = 1'b0;
    resp_ready = 1'b1;
    check("wrap_resp_count", 64'(n_resp - base_r), 64'd20);
    check("wrap_out_cnt", 64'(dut.out_cnt_q), 64'd0);

    // clk_en low for 5 cycles mid-stream: nothing moves
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'(30 + i), 3, 10'(i + 4));
    present(33, 3, 10'd7);
    clk_en = 1'b0;
    s0 = snap();
    base = n_treq;
    base_r = n_resp;
    resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ce_t_resp_ready", 64'(t_resp_ready), 64'd0);
      check("ce_outputs_hold", snap(), s0);
    end
    check("ce_no_transfer", 64'({16'(n_treq - base), 16'(n_resp - base_r)}), 64'd0);
    clk_en = 1'b1;
    wait_accept("ce_resume_accept");
    drain();

    // Async reset with 2 outstanding and 2 queued
    hold = 1'b1;
    resp_ready = 1'b0;
    t_req_ready = 1'b1;
    base = n_treq;
    send(50, 1, 10'd0);
    send(51, 1, 10'd0);
    tick();
    t_req_ready = 1'b0;
    send(52, 1, 10'd0);
    send(53, 1, 10'd0);
    check("pre_rst_issued", 64'(n_treq - base), 64'd2);
    check("pre_rst_full", 64'(req_ready), 64'd0);
    rst = 1'b1;
    #1;
    check("arst_req_ready", 64'(req_ready), 64'd1);
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_t_req_valid", 64'(t_req_valid), 64'd0);
    check("arst_t_req_data", 64'(t_req_data0), 64'd0);
`ifdef CFU_L2_BUF_STATS_EN
    check("arst_stats", 64'({stat_req, stat_stall}) | 64'(stat_peak), 64'd0);
`endif
    hold = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    t_req_ready = 1'b1;
    resp_ready = 1'b1;
    base_r = n_resp;
    send(6, 7, 10'd5);
    drain();
    check("post_rst_resp", 64'(n_resp - base_r), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
